// File: rtl/bip_control.sv
// BIP control unit: program counter, IDLE/RUN/HALT sequencing and instruction decode.
// Optional cycle counter output o_cycles enabled by defining BIP_CYCLE_CNT_EN.
module bip_control #(
  parameter int unsigned PC_W   = 11,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [OPC_W+PC_W-1:0]   i_instr,
  output logic [PC_W-1:0]         o_pc,
  output logic [PC_W-1:0]         o_addr,
  output logic [1:0]              o_selA,
  output logic                    o_selB,
  output logic                    o_op,
  output logic                    o_wrAcc,
  output logic                    o_wrRam,
  output logic                    o_rdRam,
  output logic [DATA_W-1:0]       o_SIGNAL,
  output logic                    o_busy,
  output logic                    o_halt
`ifdef BIP_CYCLE_CNT_EN
  ,
  output logic [31:0]             o_cycles
`endif
);

  localparam int unsigned INSTR_W = OPC_W + PC_W;
  localparam int unsigned EXT_W   = DATA_W - PC_W;

  localparam logic [OPC_W-1:0] OPC_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_SUBI = OPC_W'(7);

  localparam logic [1:0] SEL_RAM = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_busy;
  logic              r_halt;

  logic [OPC_W-1:0]  w_opc;
  logic [PC_W-1:0]   w_operand;
  logic [1:0]        w_sel_a;
  logic              w_sel_b;
  logic              w_op;
  logic              w_wr_acc;
  logic              w_wr_ram;
  logic              w_rd_ram;

  assign w_opc     = i_instr[INSTR_W-1 -: OPC_W];
  assign w_operand = i_instr[PC_W-1:0];

  // Sequencer: start is only honoured from IDLE/HALT; HLT freezes the PC on its own address.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_halt  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_opc == OPC_HLT) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_halt  <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency decode, gated to RUN so IDLE/HALT never strobe the datapath.
  always_comb begin
    w_sel_a  = SEL_RAM;
    w_sel_b  = 1'b0;
    w_op     = 1'b0;
    w_wr_acc = 1'b0;
    w_wr_ram = 1'b0;
    w_rd_ram = 1'b0;
    if (r_state == S_RUN) begin
      case (w_opc)
        OPC_STO:  w_wr_ram = 1'b1;
        OPC_LD: begin
          w_rd_ram = 1'b1;
          w_wr_acc = 1'b1;
        end
        OPC_LDI: begin
          w_wr_acc = 1'b1;
          w_sel_a  = SEL_IMM;
        end
        OPC_ADD: begin
          w_rd_ram = 1'b1;
          w_wr_acc = 1'b1;
          w_sel_a  = SEL_ALU;
        end
        OPC_ADDI: begin
          w_wr_acc = 1'b1;
          w_sel_a  = SEL_ALU;
          w_sel_b  = 1'b1;
        end
        OPC_SUB: begin
          w_rd_ram = 1'b1;
          w_wr_acc = 1'b1;
          w_sel_a  = SEL_ALU;
          w_op     = 1'b1;
        end
        OPC_SUBI: begin
          w_wr_acc = 1'b1;
          w_sel_a  = SEL_ALU;
          w_sel_b  = 1'b1;
          w_op     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIP_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  // Counts RUN cycles (HLT cycle included); cleared on every accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cycles <= '0;
    end else if (r_state == S_RUN) begin
      r_cycles <= r_cycles + 32'(1);
    end else if (i_start) begin
      r_cycles <= '0;
    end
  end

  assign o_cycles = r_cycles;
`endif

  assign o_pc     = r_pc;
  assign o_busy   = r_busy;
  assign o_halt   = r_halt;
  assign o_addr   = w_operand;
  assign o_SIGNAL = {{EXT_W{w_operand[PC_W-1]}}, w_operand};
  assign o_selA   = w_sel_a;
  assign o_selB   = w_sel_b;
  assign o_op     = w_op;
  assign o_wrAcc  = w_wr_acc;
  assign o_wrRam  = w_wr_ram;
  assign o_rdRam  = w_rd_ram;

endmodule

// File: doc/bip_control.md
# bip_control

Control unit for the single-accumulator BIP datapath. Holds the program counter, decodes the instruction fetched from program memory, and drives the select and strobe lines of the accumulator-input multiplexer, the operand-B multiplexer, the add/sub ALU and the data RAM. It is the stage directly upstream of the accumulator-input multiplexer: it produces that multiplexer's 2-bit select and its sign-extended immediate operand.

## Interface
- PC_W, 11, program counter / data address width
- OPC_W, 5, opcode width; instruction width = OPC_W + PC_W
- DATA_W, 16, datapath width; immediate is sign-extended to this width
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous reset, active low
- i_start  in  1  start/restart request
- i_instr  in  OPC_W+PC_W  instruction word; [15:11] opcode, [10:0] operand; comes from asynchronous-read program memory addressed by o_pc
- o_pc  out  PC_W  program counter
- o_addr  out  PC_W  data RAM address = operand field
- o_selA  out  2  accumulator mux select: 00 RAM data, 01 immediate, 10 ALU result
- o_selB  out  1  ALU operand B: 0 RAM data, 1 immediate
- o_op  out  1  ALU operation: 0 add, 1 subtract
- o_wrAcc  out  1  accumulator write enable
- o_wrRam  out  1  data RAM write enable
- o_rdRam  out  1  data RAM read enable
- o_SIGNAL  out  DATA_W  operand sign-extended from bit 10
- o_busy  out  1  high in RUN
- o_halt  out  1  high in HALT

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: i_start=1 → RUN, o_pc←0. Otherwise stay.
- RUN: i_instr decoded every cycle; o_pc←o_pc+1 unless opcode is HLT. HLT → HALT, o_pc holds address of the HLT.
- HALT: i_start=1 → RUN, o_pc←0. Otherwise stay, o_pc frozen.
- Decode (RUN only; all strobes 0 and selects 00 in IDLE/HALT):
  - 00000 HLT: no strobes.
  - 00001 STO: wrRam=1.
  - 00010 LD: rdRam=1, wrAcc=1, selA=00.
  - 00011 LDI: wrAcc=1, selA=01.
  - 00100 ADD: rdRam=1, wrAcc=1, selA=10, selB=0, op=0.
  - 00101 ADDI: wrAcc=1, selA=10, selB=1, op=0.
  - 00110 SUB: rdRam=1, wrAcc=1, selA=10, selB=0, op=1.
  - 00111 SUBI: wrAcc=1, selA=10, selB=1, op=1.
  - any other opcode: NOP, no strobes, PC increments.
- o_addr and o_SIGNAL are driven from the operand field in every state (pure wiring/extension, no strobe qualification).
- PC wrap: 2^PC_W−1 increments to 0; no halt, no flag.
- i_start while in RUN: ignored.

## Timing
- Reset: state IDLE, o_pc=0, o_busy=0, o_halt=0, all strobes 0, o_selA=00, o_selB=0, o_op=0. Reset mid-RUN takes effect at the next edge regardless of i_start; reset dominates.
- Decode outputs are combinational from i_instr and current state; zero-cycle latency.
- One instruction per cycle; o_pc advances on the edge that ends the instruction's cycle.
- o_busy/o_halt are registered state decodes: change one edge after the triggering start/HLT.
- HLT strobes nothing on its own cycle; the first HALT cycle follows.

## Configuration
- BIP_CYCLE_CNT_EN defined: adds output o_cycles (32 bits), cleared to 0 on reset and on each accepted i_start, incremented once per RUN cycle, including the HLT cycle; holds in IDLE/HALT; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset with i_start=1 held → after release o_pc=0, o_busy=0, o_halt=0, all strobes 0.
- Program LDI 5 (0x1805), ADDI −1 (0x2FFF), STO 3 (0x0803), HLT → cycle-by-cycle selA 01/10/00, selB –/1/–, o_SIGNAL 0x0005/0xFFFF, wrRam=1 only on STO with o_addr=3, o_halt=1 one edge after HLT, o_pc frozen at 3.
- LD 7 then SUB 7 → rdRam=1 both, selA 00 then 10, op=1 only on SUB, o_addr=7.
- Opcode 11111 → all strobes 0, o_pc increments.
- PC at 2047 with NOP → o_pc=0 next cycle, o_busy stays 1.
- In HALT pulse i_start → o_pc=0, RUN; assert i_rst_n=0 mid-RUN → IDLE next edge; with BIP_CYCLE_CNT_EN, o_cycles=4 after the four-instruction program above.
